// File: rtl/cfg_frame_pkg.sv
// cfg_frame_rx shared types and constants.
// Command frame layout and byte receiver state encoding.
package cfg_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int FRAME_BYTES = 3;

  localparam logic [1:0] STRT_CMD  = 2'b00;
  localparam logic [1:0] READ_EEP  = 2'b01;
  localparam logic [1:0] WRITE_EEP = 2'b10;
  localparam logic [1:0] SET_XSET  = 2'b11;

  localparam int CMD_MSB  = 19;
  localparam int CMD_LSB  = 18;
  localparam int ADDR_MSB = 17;
  localparam int ADDR_LSB = 16;

endpackage

// File: rtl/cfg_frame_rx_if.sv
// Frame hand-off between receiver and command controller.
// master = receiver side, slave = controller side.
interface cfg_frame_if;
  logic [23:0] cfg_data;
  logic        frm_rdy;
  logic        frm_ovr;
  logic        clr_rdy;

  modport master (
    output cfg_data,
    output frm_rdy,
    output frm_ovr,
    input  clr_rdy
  );

  modport slave (
    input  cfg_data,
    input  frm_rdy,
    input  frm_ovr,
    output clr_rdy
  );
endinterface

// File: rtl/cfg_frame_rx_uart_byte_rx.sv
// 8N1 byte receiver: RX synchroniser, baud counter, byte FSM.
// byte_vld_o / frm_err_o pulse in the stop-bit sample cycle.
module uart_byte_rx
  import cfg_frame_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_vld_o,
  output logic       frm_err_o,
  output logic       idle_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // s3 is only the previous synced value, used for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld_o = 1'b0;
    frm_err_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          byte_vld_o = rx_s2_q;
          frm_err_o  = !rx_s2_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_byte_o = shift_q;
  assign idle_o    = (state_q == IDLE);

endmodule

// File: rtl/cfg_frame_rx.sv
// Command-frame receiver: assembles 3 UART bytes into a 24-bit frame
// and holds it for the controller until clr_rdy.
module cfg_frame_rx
  import cfg_frame_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  cfg_frame_if.master cfg
);

  localparam int GAP_CYC = GAP_BITS * BAUD_DIV;
  localparam int GW      = $clog2(GAP_CYC);
  localparam logic [GW-1:0] GAP_M1  = GW'(GAP_CYC - 1);
  localparam logic [1:0]    LAST_IX = 2'(FRAME_BYTES - 1);

  logic [7:0]    rx_byte;
  logic          byte_vld, frm_err, rx_idle;

  logic [1:0]    idx_q, idx_d;
  logic [15:0]   buf_q, buf_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;
  logic          done;

  uart_byte_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (RX),
    .rx_byte_o  (rx_byte),
    .byte_vld_o (byte_vld),
    .frm_err_o  (frm_err),
    .idle_o     (rx_idle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      buf_q  <= '0;
      gap_q  <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      buf_q  <= buf_d;
      gap_q  <= gap_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    buf_d  = buf_q;
    gap_d  = gap_q;
    data_d = data_q;
    rdy_d  = rdy_q;
    ovr_d  = 1'b0;
    done   = 1'b0;

    // gap timer only matters between bytes of a started frame
    if (!rx_idle || idx_q == '0) begin
      gap_d = '0;
    end else if (gap_q == GAP_M1) begin
      gap_d = '0;
      idx_d = '0;
      buf_d = '0;
    end else begin
      gap_d = gap_q + GW'(1);
    end

    unique case (1'b1)
      byte_vld: begin
        if (idx_q == LAST_IX) begin
          idx_d = '0;
          buf_d = '0;
          done  = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == '0) buf_d[15:8] = rx_byte;
          else             buf_d[7:0]  = rx_byte;
        end
      end
      frm_err: begin
        idx_d = '0;
        buf_d = '0;
      end
      default: ;
    endcase

    if (done) begin
      if (!rdy_q || cfg.clr_rdy) begin
        data_d = {buf_q, rx_byte};
        rdy_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (cfg.clr_rdy) begin
      rdy_d = 1'b0;
    end
  end

  assign cfg.cfg_data = data_q;
  assign cfg.frm_rdy  = rdy_q;
  assign cfg.frm_ovr  = ovr_q;

endmodule
